// File: rtl/stream_mux_n_1.sv
// N-to-1 valid/ready stream multiplexer with a registered output stage and an accepted-beat counter.
// Optional round-robin channel advance after each transfer when STREAM_MUX_RR_EN is defined.
module stream_mux_n_1 #(
  parameter int N_CH   = 5,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH*DATA_W-1:0] my_in,
  input  logic [N_CH-1:0]        in_valid,
  output logic [N_CH-1:0]        in_ready,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   sel_load,
  output logic [DATA_W-1:0]      my_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SEL_W-1:0]       sel_q,
  output logic                   sel_err,
  output logic [15:0]            beat_cnt
);

  logic              out_free;
  logic              sel_valid;
  logic [DATA_W-1:0] sel_data;
  logic              xfer;
  logic              sel_legal;
  logic              sel_bad;
  logic [SEL_W-1:0]  sel_next;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    out_free  = !out_valid || out_ready;
    sel_valid = 1'b0;
    sel_data  = '0;
    in_ready  = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (int'(sel_q) == k) begin
        sel_valid   = in_valid[k];
        sel_data    = my_in[k*DATA_W +: DATA_W];
        in_ready[k] = out_free;
      end
    end
    xfer      = sel_valid && out_free;
    sel_legal = sel_load && (int'(sel) < N_CH);
    sel_bad   = sel_load && (int'(sel) >= N_CH);
  end

`ifdef STREAM_MUX_RR_EN
  logic             rr_found;
  logic [SEL_W-1:0] rr_next;

  // First valid channel strictly above sel_q, wrapping; sel_q itself is considered last.
  always_comb begin
    rr_found = 1'b0;
    rr_next  = sel_q;
    for (int i = 1; i < N_CH; i++) begin
      if (!rr_found && in_valid[(int'(sel_q) + i) % N_CH]) begin
        rr_found = 1'b1;
        rr_next  = SEL_W'((int'(sel_q) + i) % N_CH);
      end
    end
  end

  always_comb begin
    sel_next = sel_q;
    if (sel_legal)
      sel_next = sel;
    else if (xfer && rr_found)
      sel_next = rr_next;
  end
`else
  always_comb begin
    sel_next = sel_q;
    if (sel_legal)
      sel_next = sel;
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      my_out    <= '0;
      out_valid <= 1'b0;
      sel_q     <= '0;
      sel_err   <= 1'b0;
      beat_cnt  <= '0;
    end else begin
      // A transfer only happens when the output slot is free or draining, so a held beat is never overwritten.
      if (xfer) begin
        my_out    <= sel_data;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (out_valid && out_ready)
        beat_cnt <= beat_cnt + 16'd1;
      sel_q   <= sel_next;
      sel_err <= sel_bad;
    end
  end

endmodule

// File: tb/tb_stream_mux_n_1.sv
// Scoreboard bench for stream_mux_n_1: a driver updates a transaction-level model, a monitor checks the DUT.
module tb_stream_mux_n_1;
  localparam int N_CH   = 5;
  localparam int DATA_W = 8;
  localparam int SEL_W  = 3;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [N_CH*DATA_W-1:0] my_in;
  logic [N_CH-1:0]        in_valid;
  logic [N_CH-1:0]        in_ready;
  logic [SEL_W-1:0]       sel;
  logic                   sel_load;
  logic [DATA_W-1:0]      my_out;
  logic                   out_valid;
  logic                   out_ready;
  logic [SEL_W-1:0]       sel_q;
  logic                   sel_err;
  logic [15:0]            beat_cnt;

  always #5 clk = ~clk;

  stream_mux_n_1 #(.N_CH(N_CH), .DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst_n(rst_n), .my_in(my_in), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .sel_load(sel_load), .my_out(my_out), .out_valid(out_valid),
    .out_ready(out_ready), .sel_q(sel_q), .sel_err(sel_err), .beat_cnt(beat_cnt)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: beats accepted but not yet consumed, plus the architectural state.
  logic [DATA_W-1:0] sb[$];
  bit                occ    = 1'b0;
  logic [SEL_W-1:0]  sel_m  = '0;
  bit                err_m  = 1'b0;
  logic [15:0]       beat_m = '0;
  logic [N_CH-1:0]   exp_rdy = '0;
  bit                mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N_CH*DATA_W-1:0] put(input int ch, input logic [DATA_W-1:0] val);
    logic [N_CH*DATA_W-1:0] r;
    for (int k = 0; k < N_CH; k++) r[k*DATA_W +: DATA_W] = DATA_W'($urandom);
    r[ch*DATA_W +: DATA_W] = val;
    return r;
  endfunction

`ifdef STREAM_MUX_RR_EN
  function automatic logic [SEL_W-1:0] rr_pick(input logic [SEL_W-1:0] cur, input logic [N_CH-1:0] v);
    for (int i = 1; i < N_CH; i++)
      if (v[(int'(cur) + i) % N_CH]) return SEL_W'((int'(cur) + i) % N_CH);
    return cur;
  endfunction
`endif

  // Called just after a rising edge: drives one cycle of inputs and advances the model across the next edge.
  task automatic step(input logic [N_CH-1:0] v, input logic [N_CH*DATA_W-1:0] d, input logic ordy,
                      input logic sl, input logic [SEL_W-1:0] s, input logic rst);
    bit accept, xfer, hs;
    logic [DATA_W-1:0] dsel;
    in_valid = v; my_in = d; out_ready = ordy; sel_load = sl; sel = s; rst_n = !rst;
    accept = !occ || ordy;
    xfer   = v[int'(sel_m)] && accept;
    hs     = occ && ordy;
    dsel   = d[int'(sel_m)*DATA_W +: DATA_W];
    exp_rdy = '0;
    if (accept) exp_rdy[int'(sel_m)] = 1'b1;
    @(posedge clk);
    if (rst) begin
      sb.delete();
      occ = 1'b0; sel_m = '0; err_m = 1'b0; beat_m = '0;
    end else begin
      if (xfer) begin
        sb.push_back(dsel);
        occ = 1'b1;
      end else if (hs) begin
        occ = 1'b0;
      end
      err_m = sl && (int'(s) >= N_CH);
      if (sl && int'(s) < N_CH) sel_m = s;
`ifdef STREAM_MUX_RR_EN
      else if (xfer) sel_m = rr_pick(sel_m, v);
`endif
      beat_m = beat_m + 16'(hs);
    end
    #1;
  endtask

  // Monitor: mid-cycle comparison of every output against the model; a handshake consumes the head beat.
  always @(negedge clk) begin
    if (mon_en) begin
      check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
      if (out_valid && sb.size() != 0) check("my_out", 32'(my_out), 32'(sb[0]));
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      check("sel_q", 32'(sel_q), 32'(sel_m));
      check("sel_err", 32'(sel_err), 32'(err_m));
      check("beat_cnt", 32'(beat_cnt), 32'(beat_m));
      if (out_valid && out_ready && sb.size() != 0) void'(sb.pop_front());
    end
  end

  initial begin
    in_valid = '0; my_in = '0; out_ready = 1'b0; sel_load = 1'b0; sel = '0; rst_n = 1'b0;
    @(posedge clk); #1;
    step('0, '0, 1'b0, 1'b0, '0, 1'b1);
    step('0, '0, 1'b0, 1'b0, '0, 1'b1);
    mon_en = 1'b1;
    check("rst_in_ready", 32'(in_ready), 32'h1);

    // Select channel 2 and pass one beat straight through.
    step('0, '0, 1'b1, 1'b1, 3'd2, 1'b0);
    step(5'b00100, put(2, 8'hA5), 1'b1, 1'b0, '0, 1'b0);
    check("a5_data", 32'(my_out), 32'hA5);
    check("a5_valid", 32'(out_valid), 32'h1);
    step('0, '0, 1'b1, 1'b0, '0, 1'b0);
    check("a5_cnt", 32'(beat_cnt), 32'h1);
    check("a5_drain", 32'(out_valid), 32'h0);

    // Backpressure: 0x11 holds for three cycles, 0x22 follows once out_ready returns.
    step(5'b00100, put(2, 8'h11), 1'b0, 1'b0, '0, 1'b0);
    check("bp_first", 32'(my_out), 32'h11);
    repeat (3) begin
      step(5'b00100, put(2, 8'h22), 1'b0, 1'b0, '0, 1'b0);
      check("bp_hold", 32'(my_out), 32'h11);
      check("bp_ready2", 32'(in_ready[2]), 32'h0);
    end
    step(5'b00100, put(2, 8'h22), 1'b1, 1'b0, '0, 1'b0);
    check("bp_next", 32'(my_out), 32'h22);
    check("bp_valid", 32'(out_valid), 32'h1);
    step('0, '0, 1'b1, 1'b0, '0, 1'b0);
    check("bp_cnt", 32'(beat_cnt), 32'h3);

    // Illegal select: one-cycle error pulse, selection retained.
    step('0, '0, 1'b1, 1'b1, 3'd6, 1'b0);
    check("err_pulse", 32'(sel_err), 32'h1);
    check("err_selq", 32'(sel_q), 32'h2);
    step('0, '0, 1'b1, 1'b0, '0, 1'b0);
    check("err_clear", 32'(sel_err), 32'h0);

    // Reset while a beat is held.
    step(5'b00100, put(2, 8'h5A), 1'b0, 1'b0, '0, 1'b0);
    check("held_valid", 32'(out_valid), 32'h1);
    step('0, '0, 1'b0, 1'b0, '0, 1'b1);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_selq", 32'(sel_q), 32'h0);
    check("rst_cnt", 32'(beat_cnt), 32'h0);
    check("rst_ready", 32'(in_ready), 32'h1);

    // Random traffic with select loads (legal and illegal) and occasional reset.
    repeat (3000) begin
      step(N_CH'($urandom), put(0, DATA_W'($urandom)), ($urandom % 4) != 0,
           ($urandom % 8) == 0, SEL_W'($urandom), ($urandom % 200) == 0);
    end

    // Full-rate stream of 65536 beats: the counter wraps back to zero.
    step('0, '0, 1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 65537; i++)
      step('1, put(0, DATA_W'($urandom)), 1'b1, 1'b0, '0, 1'b0);
    check("wrap_cnt", 32'(beat_cnt), 32'h0);
    check("wrap_valid", 32'(out_valid), 32'h1);
    step('0, '0, 1'b1, 1'b0, '0, 1'b0);

`ifdef STREAM_MUX_RR_EN
    begin
      int order[6] = '{0, 1, 3, 0, 1, 3};
      logic [N_CH*DATA_W-1:0] d;
      step('0, '0, 1'b0, 1'b0, '0, 1'b1);
      for (int k = 0; k < N_CH; k++) d[k*DATA_W +: DATA_W] = DATA_W'(8'h30 + k);
      for (int i = 0; i < 6; i++) begin
        step(5'b01011, d, 1'b1, 1'b0, '0, 1'b0);
        check("rr_grant", 32'(my_out), 32'(8'h30 + order[i]));
      end
      step('0, '0, 1'b1, 1'b0, '0, 1'b0);
    end
`endif

    step('0, '0, 1'b1, 1'b0, '0, 1'b0);
    step('0, '0, 1'b1, 1'b0, '0, 1'b0);
    @(negedge clk);
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
